// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXE/MEM/WB from the opcode/funct
// held in IR, drives the datapath controls combinationally, and counts retired instructions.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic [1:0]       EXTOp,
    output logic [2:0]       ALUOp,
    output logic             if_beq,
    output logic             if_jal,
    output logic             if_jr,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             fin;

    logic [5:0] op, fn;
    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    logic legal;
    logic unused_instr;

    assign op           = instr[31:26];
    assign fn           = instr[5:0];
    assign unused_instr = ^instr[25:6];

    assign is_r    = (op == 6'h00);
    assign is_addu = is_r && (fn == 6'h21);
    assign is_subu = is_r && (fn == 6'h23);
    assign is_jr   = is_r && (fn == 6'h08);
    assign is_ori  = (op == 6'h0d);
    assign is_lui  = (op == 6'h0f);
    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2b);
    assign is_beq  = (op == 6'h04);
    assign is_j    = (op == 6'h02);
    assign is_jal  = (op == 6'h03);
    assign legal   = is_addu | is_subu | is_jr | is_ori | is_lui | is_lw | is_sw |
                     is_beq | is_j | is_jal;

    always_comb begin
        state_d = S_FETCH;
        fin     = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                fin     = is_j | is_jal;
                state_d = (is_j | is_jal | !legal) ? S_FETCH : S_EXE;
            end
            S_EXE: begin
                fin = is_beq | is_jr;
                if (is_lw | is_sw)        state_d = S_MEM;
                else if (is_beq | is_jr)  state_d = S_FETCH;
                else                      state_d = S_WB;
            end
            S_MEM: begin
                fin     = is_sw;
                state_d = is_lw ? S_WB : S_FETCH;
            end
            S_WB:     fin = 1'b1;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (fin) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

    // Everything is gated by reset so an aborted instruction cannot write.
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        EXTOp    = 2'b00;
        ALUOp    = 3'b000;
        if_beq   = 1'b0;
        if_jal   = 1'b0;
        if_jr    = 1'b0;
        illegal  = 1'b0;
        if (reset) begin
            if (state_q == S_FETCH) begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
            end else if (state_q == S_DECODE || state_q == S_EXE ||
                         state_q == S_MEM || state_q == S_WB) begin
                // Selects stay constant from DECODE to the final state.
                RegDst   = is_addu | is_subu;
                ALUSrc   = is_ori | is_lui | is_lw | is_sw;
                MemToReg = is_lw;
                EXTOp    = is_lui ? 2'b10 : ((is_lw | is_sw) ? 2'b01 : 2'b00);
                ALUOp    = (is_subu | is_beq) ? 3'b001 : (is_ori ? 3'b010 : 3'b000);
                if_beq   = is_beq;
                if_jal   = is_jal;
                if_jr    = is_jr;
                case (state_q)
                    S_DECODE: begin
                        PCWrite  = is_j | is_jal;
                        RegWrite = is_jal;
                        illegal  = !legal;
                    end
                    S_EXE:   PCWrite  = is_jr | (is_beq & zero);
                    S_MEM:   MemWrite = is_sw;
                    S_WB:    RegWrite = 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expected control vectors are queued when an
// instruction is issued and popped against the outputs of a 32-bit and a 3-bit counter DUT.
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw, irw, rdst, rw, asrc, mw, m2r;
        logic [1:0] ext;
        logic [2:0] aop;
        logic       beq, jal, jr, ill;
    } vec_t;

    typedef enum {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_LW_ABORT, K_SW, K_BEQ, K_JR, K_J,
                  K_JAL, K_ILL} kind_e;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;

    logic        PCWrite, IRWrite, RegDst, RegWrite, ALUSrc, MemWrite, MemToReg;
    logic [1:0]  EXTOp;
    logic [2:0]  ALUOp;
    logic        if_beq, if_jal, if_jr, illegal;
    logic [2:0]  state;
    logic [31:0] retired;

    logic        s_PCWrite, s_IRWrite, s_RegDst, s_RegWrite, s_ALUSrc, s_MemWrite, s_MemToReg;
    logic [1:0]  s_EXTOp;
    logic [2:0]  s_ALUOp;
    logic        s_if_beq, s_if_jal, s_if_jr, s_illegal;
    logic [2:0]  s_state;
    logic [2:0]  s_retired;

    vec_t obs_v, obs_s;
    assign obs_v = {state, PCWrite, IRWrite, RegDst, RegWrite, ALUSrc, MemWrite, MemToReg,
                    EXTOp, ALUOp, if_beq, if_jal, if_jr, illegal};
    assign obs_s = {s_state, s_PCWrite, s_IRWrite, s_RegDst, s_RegWrite, s_ALUSrc, s_MemWrite,
                    s_MemToReg, s_EXTOp, s_ALUOp, s_if_beq, s_if_jal, s_if_jr, s_illegal};

    mc_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemToReg(MemToReg), .EXTOp(EXTOp),
        .ALUOp(ALUOp), .if_beq(if_beq), .if_jal(if_jal), .if_jr(if_jr),
        .state(state), .illegal(illegal), .retired(retired)
    );

    // Narrow counter copy shares the stimulus so the modulo wrap is reached quickly.
    mc_ctrl #(.CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .PCWrite(s_PCWrite), .IRWrite(s_IRWrite), .RegDst(s_RegDst), .RegWrite(s_RegWrite),
        .ALUSrc(s_ALUSrc), .MemWrite(s_MemWrite), .MemToReg(s_MemToReg), .EXTOp(s_EXTOp),
        .ALUOp(s_ALUOp), .if_beq(s_if_beq), .if_jal(s_if_jal), .if_jr(s_if_jr),
        .state(s_state), .illegal(s_illegal), .retired(s_retired)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cnt   = 0;
    vec_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] st, input logic pcw, input logic irw,
                                input logic rw, input logic mw, input vec_t sel);
        vec_t r;
        r     = sel;
        r.st  = st;
        r.pcw = pcw;
        r.irw = irw;
        r.rw  = rw;
        r.mw  = mw;
        return r;
    endfunction

    task automatic issue(input kind_e k, input logic [31:0] ins, input logic z);
        vec_t s;
        int   ncyc;
        s     = '0;
        instr = ins;
        zero  = z;
        sb.push_back(mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, '0));
        case (k)
            K_ADDU, K_SUBU: begin
                s.rdst = 1'b1;
                s.aop  = (k == K_SUBU) ? 3'b001 : 3'b000;
                sb.push_back(mk(3'd1, 0, 0, 0, 0, s));
                sb.push_back(mk(3'd2, 0, 0, 0, 0, s));
                sb.push_back(mk(3'd4, 0, 0, 1, 0, s));
            end
            K_ORI, K_LUI: begin
                s.asrc = 1'b1;
                s.aop  = (k == K_ORI) ? 3'b010 : 3'b000;
                s.ext  = (k == K_LUI) ? 2'b10 : 2'b00;
                sb.push_back(mk(3'd1, 0, 0, 0, 0, s));
                sb.push_back(mk(3'd2, 0, 0, 0, 0, s));
                sb.push_back(mk(3'd4, 0, 0, 1, 0, s));
            end
            K_LW, K_LW_ABORT: begin
                s.asrc = 1'b1;
                s.ext  = 2'b01;
                s.m2r  = 1'b1;
                sb.push_back(mk(3'd1, 0, 0, 0, 0, s));
                sb.push_back(mk(3'd2, 0, 0, 0, 0, s));
                if (k == K_LW) begin
                    sb.push_back(mk(3'd3, 0, 0, 0, 0, s));
                    sb.push_back(mk(3'd4, 0, 0, 1, 0, s));
                end
            end
            K_SW: begin
                s.asrc = 1'b1;
                s.ext  = 2'b01;
                sb.push_back(mk(3'd1, 0, 0, 0, 0, s));
                sb.push_back(mk(3'd2, 0, 0, 0, 0, s));
                sb.push_back(mk(3'd3, 0, 0, 0, 1, s));
            end
            K_BEQ: begin
                s.aop = 3'b001;
                s.beq = 1'b1;
                sb.push_back(mk(3'd1, 0, 0, 0, 0, s));
                sb.push_back(mk(3'd2, z, 0, 0, 0, s));
            end
            K_JR: begin
                s.jr = 1'b1;
                sb.push_back(mk(3'd1, 0, 0, 0, 0, s));
                sb.push_back(mk(3'd2, 1, 0, 0, 0, s));
            end
            K_J:   sb.push_back(mk(3'd1, 1, 0, 0, 0, s));
            K_JAL: begin
                s.jal = 1'b1;
                sb.push_back(mk(3'd1, 1, 0, 1, 0, s));
            end
            default: begin
                s.ill = 1'b1;
                sb.push_back(mk(3'd1, 0, 0, 0, 0, s));
            end
        endcase
        ncyc = 0;
        while (sb.size() > 0 && ncyc < 8) begin
            vec_t e;
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("%s c%0d", k.name(), ncyc), 32'(obs_v), 32'(e));
            check($sformatf("%s c%0d narrow", k.name(), ncyc), 32'(obs_s), 32'(e));
            @(posedge clk);
            #1;
            ncyc++;
        end
        if (k != K_ILL && k != K_LW_ABORT) cnt++;
        if (k != K_LW_ABORT) begin
            check($sformatf("%s end state", k.name()), 32'(state), 32'd0);
            check($sformatf("%s retired", k.name()), retired, 32'(cnt));
            check($sformatf("%s retired narrow", k.name()), 32'(s_retired), 32'(cnt % 8));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        instr = 32'h0;
        zero  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("por vector", 32'(obs_v), 32'd0);
        check("por retired", retired, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // lw aborted by reset while in MEM
        issue(K_LW_ABORT, 32'h8C040000, 1'b0);
        check("abort pre-reset state", 32'(state), 32'd3);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset c%0d vector", i), 32'(obs_v), 32'd0);
            check($sformatf("reset c%0d narrow", i), 32'(obs_s), 32'd0);
            check($sformatf("reset c%0d retired", i), retired, 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;

        issue(K_ADDU, 32'h00221821, 1'b0);
        issue(K_LW,   32'h8C040000, 1'b0);
        issue(K_SW,   32'hAC040004, 1'b0);
        issue(K_BEQ,  32'h10220001, 1'b1);
        issue(K_BEQ,  32'h10220001, 1'b0);
        issue(K_JAL,  32'h0C000010, 1'b0);
        issue(K_JR,   32'h03E00008, 1'b1);
        issue(K_ILL,  32'hFC000000, 1'b0);
        issue(K_SUBU, 32'h00221823, 1'b0);
        issue(K_ILL,  32'h00221820, 1'b0);
        issue(K_ORI,  32'h34010005, 1'b0);
        issue(K_LUI,  32'h3C021234, 1'b0);
        issue(K_J,    32'h08000004, 1'b0);
        issue(K_ADDU, 32'h00221821, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
